pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Supervises a PLL such as the TMDS clock PLL. It drives the PLL reset, qualifies the asynchronous lock flag with a filter and a timeout, and retries the PLL a bounded number of times. Once lock is qualified, it releases a parametrised set of downstream synchronous resets one after another. It sits between the PLL instance and the video, TMDS and LUT-network reset trees, and runs entirely on the PLL reference clock.

## Interface
Parameters:
- NUM_RST, 3: number of staggered downstream reset outputs (1..8).
- LOCK_FILTER, 1024: consecutive synchronised-lock cycles required to qualify lock.
- LOCK_TIMEOUT, 65536: maximum cycles spent in WAIT_LOCK per attempt. Must be greater than LOCK_FILTER.
- PLL_RST_CYCLES, 16: width of each pll_reset pulse, in cycles (at least 1).
- STAGGER, 8: cycles between successive rst_out releases (at least 1).
- MAX_RETRY, 7: retries allowed after the first attempt before entering FAULT.

Ports:
- clkin, input, 1: reference clock; the only clock.
- reset, input, 1: synchronous, active-high.
- lock_in, input, 1: PLL lock, asynchronous to clkin.
- force_relock, input, 1: single-cycle request to restart the PLL.
- clear_status, input, 1: clears lock_lost.
- pll_reset, output, 1: drives the PLL RESET input.
- rst_out, output, NUM_RST: downstream resets, active-high.
- ready, output, 1: high only in RUN.
- fault, output, 1: high only in FAULT.
- lock_lost, output, 1: sticky flag; set when lock is lost while in RUN.
- retry_cnt, output, clog2(MAX_RETRY+1): timeouts counted since the last entry to RUN.

## Operation
- Synchroniser: lock_in passes through a 2-flop synchroniser to give lock_s. All decisions use lock_s only.
- All outputs are registered.
- Reset values: pll_reset=1, rst_out all 1, ready=0, fault=0, lock_lost=0, retry_cnt=0, synchroniser flops 0, counters 0, state PLL_RST.
- State PLL_RST:
  - pll_reset=1 and all rst_out=1.
  - lock_s is ignored.
  - Lasts PLL_RST_CYCLES cycles, then goes to WAIT_LOCK with the filter and timeout counters cleared.
- State WAIT_LOCK:
  - pll_reset=0.
  - The filter counter increments on each cycle lock_s=1 and clears on any cycle lock_s=0.
  - After LOCK_FILTER consecutive high cycles, go to RELEASE.
  - Otherwise, after LOCK_TIMEOUT cycles in the state:
    - if retry_cnt<MAX_RETRY, increment retry_cnt and go to PLL_RST;
    - if retry_cnt==MAX_RETRY, go to FAULT.
  - If the filter completes on the same cycle as the timeout, the filter wins.
- State RELEASE:
  - Lasts NUM_RST*STAGGER cycles.
  - rst_out[k] goes low starting at RELEASE cycle (k+1)*STAGGER, counting the first RELEASE cycle as 1. Once low, it stays low.
  - If lock_s=0 in this state: set lock_lost, assert all rst_out on the next cycle, go to PLL_RST. retry_cnt is unchanged.
- State RUN:
  - ready=1, all rst_out=0, and retry_cnt clears on entry.
  - If lock_s=0: lock_lost=1, ready=0 and all rst_out=1 on the next cycle, then go to PLL_RST.
- State FAULT:
  - fault=1, pll_reset=1, all rst_out=1.
  - Leaves only on reset or force_relock. On force_relock, retry_cnt clears and the next state is PLL_RST.
- force_relock in any state other than FAULT: go to PLL_RST next cycle and clear retry_cnt. lock_lost is not set.
- Simultaneous lock loss and force_relock in RUN: lock_lost is set.
- lock_lost set and clear_status on the same cycle: set wins.
- reset overrides everything on any cycle, including mid-RELEASE and in FAULT.

## Timing
- Cycle 0 is the first cycle with reset=0, with lock_in held high throughout:
  - pll_reset is high for cycles 0..PLL_RST_CYCLES-1.
  - rst_out[k] falls at cycle PLL_RST_CYCLES+LOCK_FILTER+(k+1)*STAGGER.
  - ready rises at cycle PLL_RST_CYCLES+LOCK_FILTER+NUM_RST*STAGGER.
- lock_in falling to reaction: the 2-cycle synchroniser plus 1 registered cycle gives ready=0 and rst_out=1 3 cycles after the lock_in edge.
- Per-attempt period with no lock: PLL_RST_CYCLES+LOCK_TIMEOUT.
- Time to FAULT: (MAX_RETRY+1) attempts.

## Test plan
Bench parameters for all cases: NUM_RST=3, LOCK_FILTER=8, LOCK_TIMEOUT=32, PLL_RST_CYCLES=4, STAGGER=2, MAX_RETRY=2.
1. Clean lock, lock_in=1 throughout → pll_reset high on cycles 0-3; rst_out[0] falls at 14, rst_out[1] at 16, rst_out[2] at 18; ready=1 at 18; retry_cnt=0.
2. lock_in=0 forever → timeouts at cycles 36 and 72 bring retry_cnt to 1 then 2; fault=1 from cycle 108 with pll_reset=1 held; force_relock then gives retry_cnt=0 and a new PLL_RST.
3. A 1-cycle low glitch on lock_in after 5 high cycles in WAIT_LOCK → filter restarts; ready is delayed by exactly the glitch offset plus 1 relative to case 1.
4. In RUN, lock_in drops at cycle T → ready=0, rst_out=3'b111, lock_lost=1 at T+3; full sequence repeats; a later clear_status drops lock_lost.
5. force_relock and a lock drop on the same cycle in RUN → lock_lost=1, PLL_RST entered; lock_lost set and clear_status on the same cycle → lock_lost stays 1.
6. reset asserted mid-RELEASE (rst_out[0] already low) → next cycle shows every output at its reset value, including rst_out=3'b111.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL supervisor: pulses the PLL reset, qualifies lock with a filter and timeout,
// retries a bounded number of times, then releases downstream resets in sequence.
module pll_lock_supervisor #(
  parameter int NUM_RST        = 3,
  parameter int LOCK_FILTER    = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 16,
  parameter int STAGGER        = 8,
  parameter int MAX_RETRY      = 7,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               lock_in,
  input  logic               force_relock,
  input  logic               clear_status,
  output logic               pll_reset,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic               fault,
  output logic               lock_lost,
  output logic [RW-1:0]      retry_cnt
);

  localparam int REL_LEN = NUM_RST * STAGGER;
  localparam int CMAX_A  = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int CMAX    = (CMAX_A > REL_LEN) ? CMAX_A : REL_LEN;
  localparam int CW      = $clog2(CMAX + 1);
  localparam int FW      = $clog2(LOCK_FILTER + 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, lock_s_q;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [FW-1:0]      filt_q, filt_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic               lost_q, lost_d, lost_set;
  logic               pll_reset_q, pll_reset_d;
  logic [NUM_RST-1:0] rst_out_q, rst_out_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic [NUM_RST-1:0] rel_due;

  assign cnt_inc = cnt_q + CW'(1);

  // rel_due[k]: the current RELEASE cycle (1-based) has reached reset k's release point
  for (genvar gi = 0; gi < NUM_RST; gi++) begin : g_rel
    localparam logic [CW-1:0] THR = CW'((gi + 1) * STAGGER);
    assign rel_due[gi] = (cnt_inc >= THR);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    filt_d   = '0;
    retry_d  = retry_q;
    lost_set = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        filt_d = lock_s_q ? filt_q + FW'(1) : '0;
        if (lock_s_q && (filt_q == FW'(LOCK_FILTER - 1))) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = S_PLL_RST;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_RELEASE: begin
        if (!lock_s_q) begin
          lost_set = 1'b1;
          state_d  = S_PLL_RST;
          cnt_d    = '0;
        end else if (cnt_q == CW'(REL_LEN - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s_q) begin
          lost_set = 1'b1;
          state_d  = S_PLL_RST;
          cnt_d    = '0;
        end
      end
      S_FAULT: cnt_d = cnt_q;
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    if (force_relock) begin
      state_d = S_PLL_RST;
      cnt_d   = '0;
      filt_d  = '0;
      retry_d = '0;
    end

    lost_d      = lost_set | (lost_q & ~clear_status);
    pll_reset_d = (state_d == S_PLL_RST) || (state_d == S_FAULT);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
    // Outputs are registered from the next state so they line up with it
    if (state_d == S_RUN) begin
      rst_out_d = '0;
    end else if ((state_q == S_RELEASE) && (state_d == S_RELEASE)) begin
      rst_out_d = ~rel_due;
    end else begin
      rst_out_d = '1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      filt_q      <= '0;
      retry_q     <= '0;
      lost_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync1_q     <= lock_in;
      lock_s_q    <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pll_reset_q <= pll_reset_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign lock_lost = lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed test-plan cases then random lock/relock
// traffic, all compared cycle by cycle against a timestamp-based phase model.
module tb_pll_lock_supervisor;

  localparam int NUM_RST        = 3;
  localparam int LOCK_FILTER    = 8;
  localparam int LOCK_TIMEOUT   = 32;
  localparam int PLL_RST_CYCLES = 4;
  localparam int STAGGER        = 2;
  localparam int MAX_RETRY      = 2;
  localparam int RW             = $clog2(MAX_RETRY + 1);

  localparam int PH_RST   = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_REL   = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_FAULT = 4;

  logic               clkin = 1'b0;
  logic               reset, lock_in, force_relock, clear_status;
  logic               pll_reset, ready, fault, lock_lost;
  logic [NUM_RST-1:0] rst_out;
  logic [RW-1:0]      retry_cnt;

  always #5 clkin = ~clkin;

  pll_lock_supervisor #(
    .NUM_RST(NUM_RST), .LOCK_FILTER(LOCK_FILTER), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .PLL_RST_CYCLES(PLL_RST_CYCLES), .STAGGER(STAGGER), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clkin(clkin), .reset(reset), .lock_in(lock_in), .force_relock(force_relock),
    .clear_status(clear_status), .pll_reset(pll_reset), .rst_out(rst_out),
    .ready(ready), .fault(fault), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: current phase plus the cycle it began; outputs follow by arithmetic.
  int cyc;
  int m_phase, m_t0, m_last_low, m_retry;
  bit m_lost;
  bit hist [0:16383];
  int ready_rise, fault_rise;
  int rst_fall [NUM_RST];

  task automatic model_reset();
    m_phase    = PH_RST;
    m_t0       = 0;
    m_last_low = 0;
    m_retry    = 0;
    m_lost     = 1'b0;
  endtask

  task automatic model_step(input bit ls, input bit fr, input bit cs);
    int n;
    bit lost_set;
    n = cyc;
    lost_set = 1'b0;
    case (m_phase)
      PH_RST: if (n - m_t0 + 1 == PLL_RST_CYCLES) begin
        m_phase = PH_WAIT; m_t0 = n + 1; m_last_low = n;
      end
      PH_WAIT: begin
        if (!ls) m_last_low = n;
        if (ls && (n - m_last_low == LOCK_FILTER)) begin
          m_phase = PH_REL; m_t0 = n + 1;
        end else if (n - m_t0 + 1 == LOCK_TIMEOUT) begin
          m_t0 = n + 1;
          if (m_retry < MAX_RETRY) begin
            m_retry++; m_phase = PH_RST;
          end else begin
            m_phase = PH_FAULT;
          end
        end
      end
      PH_REL: begin
        if (!ls) begin
          lost_set = 1'b1; m_phase = PH_RST; m_t0 = n + 1;
        end else if (n - m_t0 + 1 == NUM_RST * STAGGER) begin
          m_phase = PH_RUN; m_t0 = n + 1; m_retry = 0;
        end
      end
      PH_RUN: if (!ls) begin
        lost_set = 1'b1; m_phase = PH_RST; m_t0 = n + 1;
      end
      default: ;
    endcase
    if (fr) begin
      m_phase = PH_RST; m_t0 = n + 1; m_retry = 0;
    end
    m_lost = lost_set | (m_lost & ~cs);
  endtask

  function automatic logic [31:0] model_vec();
    logic [NUM_RST-1:0] r;
    logic [RW-1:0] rc;
    r = '1;
    if (m_phase == PH_RUN) r = '0;
    if (m_phase == PH_REL)
      for (int k = 0; k < NUM_RST; k++) r[k] = !((cyc - m_t0) >= (k + 1) * STAGGER);
    rc = RW'(m_retry);
    return {23'b0, (m_phase == PH_RST) || (m_phase == PH_FAULT), r,
            m_phase == PH_RUN, m_phase == PH_FAULT, m_lost, rc};
  endfunction

  task automatic arm();
    ready_rise = -1;
    fault_rise = -1;
    for (int k = 0; k < NUM_RST; k++) rst_fall[k] = -1;
  endtask

  task automatic tick(input bit lk, input bit fr, input bit cs, input bit rs);
    bit ls;
    lock_in = lk; force_relock = fr; clear_status = cs; reset = rs;
    @(posedge clkin);
    if (rs) begin
      model_reset();
      cyc = 0;
    end else begin
      hist[cyc % 16384] = lk;
      ls = (cyc >= 2) ? hist[(cyc - 2) % 16384] : 1'b0;
      model_step(ls, fr, cs);
      cyc++;
    end
    #1;
    check_eq($sformatf("cyc%0d", cyc),
             {23'b0, pll_reset, rst_out, ready, fault, lock_lost, retry_cnt}, model_vec());
    if (ready && ready_rise < 0) ready_rise = cyc;
    if (fault && fault_rise < 0) fault_rise = cyc;
    for (int k = 0; k < NUM_RST; k++)
      if (!rst_out[k] && rst_fall[k] < 0) rst_fall[k] = cyc;
  endtask

  initial begin
    int t;
    bit cur;
    int seg_left;
    lock_in = 1'b0; force_relock = 1'b0; clear_status = 1'b0; reset = 1'b1;
    cyc = 0;
    model_reset();
    arm();

    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("reset_state", {23'b0, pll_reset, rst_out, ready, fault, lock_lost, retry_cnt},
             32'b1_111_0_0_0_00);

    // Case 1: clean lock
    arm();
    repeat (30) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("c1_rst0_fall", rst_fall[0], 14);
    check_eq("c1_rst1_fall", rst_fall[1], 16);
    check_eq("c1_rst2_fall", rst_fall[2], 18);
    check_eq("c1_ready_rise", ready_rise, 18);
    check_eq("c1_retry", retry_cnt, 0);
    $display("case1 clean lock: ready rose at cycle %0d", ready_rise);

    // Case 2: never locks -> FAULT, then force_relock
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    arm();
    repeat (37) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("c2_retry1", retry_cnt, 1);
    repeat (78) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("c2_fault_rise", fault_rise, 108);
    check_eq("c2_fault_pll", {fault, pll_reset, retry_cnt}, 4'b11_10);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("c2_relock", {fault, pll_reset, retry_cnt}, 4'b01_00);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    $display("case2 no lock: fault rose at cycle %0d", fault_rise);

    // Case 3: one-cycle glitch after 5 high filter cycles
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    arm();
    repeat (40) tick(cyc != 7, 1'b0, 1'b0, 1'b0);
    check_eq("c3_ready_rise", ready_rise, 24);
    $display("case3 glitch: ready rose at cycle %0d", ready_rise);

    // Case 4: lock drop in RUN, recovery, clear_status
    t = cyc;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("c4_react", {ready, rst_out, lock_lost}, 5'b0_111_1);
    repeat (40) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("c4_rerun", {ready, lock_lost}, 2'b11);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("c4_clear", lock_lost, 0);
    $display("case4 lock drop at cycle %0d handled", t);

    // Case 5: force_relock coincident with lock loss; set vs clear
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("c5_force_lost", {lock_lost, pll_reset, ready}, 3'b110);
    repeat (30) tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("c5_pre_clear", {ready, lock_lost}, 2'b10);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("c5_set_wins", lock_lost, 1);
    $display("case5 force+loss and set/clear collision done");

    // Case 6: reset mid-RELEASE
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (15) tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("c6_mid_release", {ready, rst_out}, 4'b0_110);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("c6_reset_vals", {23'b0, pll_reset, rst_out, ready, fault, lock_lost, retry_cnt},
             32'b1_111_0_0_0_00);
    $display("case6 reset mid-release done");

    // Random lock traffic with occasional relock, clear and reset
    cur = 1'b0;
    seg_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg_left == 0) begin
        cur = ~cur;
        if (cur) seg_left = $urandom_range(1, 60);
        else if ($urandom_range(0, 7) == 0) seg_left = $urandom_range(40, 150);
        else seg_left = $urandom_range(1, 8);
      end
      seg_left--;
      tick(cur, $urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 999) == 0);
    end
    $display("random: 3000 cycles applied");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
